// File: rtl/axil_cfg_master_pkg.sv
// ============================================================================
// axil_cfg_master_pkg : FSM state encoding and AXI response codes
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

package axil_cfg_master_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WADDR_DATA = 3'd1,
    ST_WRESP      = 3'd2,
    ST_RADDR      = 3'd3,
    ST_RDATA      = 3'd4,
    ST_RESP       = 3'd5
  } state_e;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

endpackage

`default_nettype wire

// File: rtl/axil_cfg_master_if.sv
// ============================================================================
// axil_cfg_master_if : AXI4-Lite cfg bus (32-bit address/data, 4-bit strobes)
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

interface axil_cfg_master_if;

  logic        awvalid;
  logic        awready;
  logic [31:0] awaddr;
  logic        wvalid;
  logic        wready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        bvalid;
  logic        bready;
  logic [1:0]  bresp;
  logic        arvalid;
  logic        arready;
  logic [31:0] araddr;
  logic        rvalid;
  logic        rready;
  logic [31:0] rdata;
  logic [1:0]  rresp;

  modport master (
    output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport slave (
    input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

endinterface

`default_nettype wire

// File: rtl/axil_cfg_master.sv
// ============================================================================
// axil_cfg_master : single-outstanding AXI4-Lite initiator for cfg register bus
// Optional response timeout: define AXIL_CFG_MASTER_TIMEOUT_EN
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module axil_cfg_master
  import axil_cfg_master_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_write_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [3:0]  req_wstrb_i,
  output logic        resp_valid_o,
  output logic [31:0] resp_rdata_o,
  output logic [1:0]  resp_code_o,
  axil_cfg_master_if.master cfg
);

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("axil_cfg_master: TIMEOUT_CYCLES must be in 2..65535");
  end

  state_e      state_q, state_d;
  logic        awvalid_q, awvalid_d;
  logic        wvalid_q, wvalid_d;
  logic        arvalid_q, arvalid_d;
  logic        bready_q, bready_d;
  logic        rready_q, rready_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        resp_valid_q, resp_valid_d;
  logic [1:0]  resp_code_q, resp_code_d;
  logic [31:0] rdata_q, rdata_d;

  logic accept;
  logic aw_hs, w_hs, ar_hs, b_hs, r_hs;
  logic aw_left, w_left;
  logic timeout_hit;
  logic idle_absorb;

  assign accept  = req_valid_i & (state_q == ST_IDLE);
  assign aw_hs   = awvalid_q & cfg.awready;
  assign w_hs    = wvalid_q & cfg.wready;
  assign ar_hs   = arvalid_q & cfg.arready;
  assign b_hs    = bready_q & cfg.bvalid;
  assign r_hs    = rready_q & cfg.rvalid;
  // A channel still owes a beat if its valid is up and not being accepted now
  assign aw_left = awvalid_q & ~cfg.awready;
  assign w_left  = wvalid_q & ~cfg.wready;

`ifdef AXIL_CFG_MASTER_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] cnt_q, cnt_d;

  assign timeout_hit = (cnt_q == TO_LAST);
  assign idle_absorb = 1'b1;

  // Clears on entry to a response-wait state, counts while staying there
  always_comb begin
    cnt_d = 16'd0;
    if ((state_d == ST_WRESP || state_d == ST_RDATA) && (state_q == state_d)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= 16'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign idle_absorb = 1'b0;
`endif

  // State and registered outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ST_IDLE;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      arvalid_q    <= 1'b0;
      bready_q     <= 1'b0;
      rready_q     <= 1'b0;
      addr_q       <= 32'd0;
      wdata_q      <= 32'd0;
      wstrb_q      <= 4'd0;
      resp_valid_q <= 1'b0;
      resp_code_q  <= 2'b00;
      rdata_q      <= 32'd0;
    end else begin
      state_q      <= state_d;
      awvalid_q    <= awvalid_d;
      wvalid_q     <= wvalid_d;
      arvalid_q    <= arvalid_d;
      bready_q     <= bready_d;
      rready_q     <= rready_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
      resp_valid_q <= resp_valid_d;
      resp_code_q  <= resp_code_d;
      rdata_q      <= rdata_d;
    end
  end

  // Next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = req_write_i ? ST_WADDR_DATA : ST_RADDR;
        end
      end
      ST_WADDR_DATA: begin
        if (!aw_left && !w_left) begin
          state_d = ST_WRESP;
        end
      end
      ST_WRESP: begin
        if (b_hs || timeout_hit) begin
          state_d = ST_RESP;
        end
      end
      ST_RADDR: begin
        if (ar_hs) begin
          state_d = ST_RDATA;
        end
      end
      ST_RDATA: begin
        if (r_hs || timeout_hit) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs
  always_comb begin
    awvalid_d    = awvalid_q;
    wvalid_d     = wvalid_q;
    arvalid_d    = arvalid_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    resp_code_d  = resp_code_q;
    rdata_d      = rdata_q;
    resp_valid_d = 1'b0;
    bready_d     = (state_d == ST_WRESP) | (idle_absorb & (state_d == ST_IDLE));
    rready_d     = (state_d == ST_RDATA) | (idle_absorb & (state_d == ST_IDLE));

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          addr_d = req_addr_i;
          if (req_write_i) begin
            wdata_d   = req_wdata_i;
            wstrb_d   = req_wstrb_i;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else begin
            arvalid_d = 1'b1;
          end
        end
      end
      ST_WADDR_DATA: begin
        if (aw_hs) awvalid_d = 1'b0;
        if (w_hs)  wvalid_d  = 1'b0;
      end
      ST_WRESP: begin
        if (state_d == ST_RESP) begin
          resp_valid_d = 1'b1;
          resp_code_d  = b_hs ? cfg.bresp : AXI_RESP_DECERR;
          rdata_d      = 32'd0;
        end
      end
      ST_RADDR: begin
        if (ar_hs) arvalid_d = 1'b0;
      end
      ST_RDATA: begin
        if (state_d == ST_RESP) begin
          resp_valid_d = 1'b1;
          resp_code_d  = r_hs ? cfg.rresp : AXI_RESP_DECERR;
          rdata_d      = r_hs ? cfg.rdata : 32'd0;
        end
      end
      default: ;
    endcase
  end

  assign req_ready_o  = (state_q == ST_IDLE);
  assign resp_valid_o = resp_valid_q;
  assign resp_code_o  = resp_code_q;
  assign resp_rdata_o = rdata_q;

  assign cfg.awvalid  = awvalid_q;
  assign cfg.awaddr   = addr_q;
  assign cfg.wvalid   = wvalid_q;
  assign cfg.wdata    = wdata_q;
  assign cfg.wstrb    = wstrb_q;
  assign cfg.bready   = bready_q;
  assign cfg.arvalid  = arvalid_q;
  assign cfg.araddr   = addr_q;
  assign cfg.rready   = rready_q;

endmodule

`default_nettype wire

// File: tb/tb_axil_cfg_master.sv
// ============================================================================
// tb_axil_cfg_master : vector table + response scoreboard for axil_cfg_master
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_axil_cfg_master;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_wstrb;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic [1:0]  resp_code;

  axil_cfg_master_if bus ();

  axil_cfg_master #(.TIMEOUT_CYCLES(16)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_write_i  (req_write),
    .req_addr_i   (req_addr),
    .req_wdata_i  (req_wdata),
    .req_wstrb_i  (req_wstrb),
    .resp_valid_o (resp_valid),
    .resp_rdata_o (resp_rdata),
    .resp_code_o  (resp_code),
    .cfg          (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [31:0] rdata;
    logic [1:0]  code;
  } exp_t;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;   // wdata for writes, slave rdata for reads
    logic [3:0]  strb;
    int          d_a;    // AW or AR ready delay
    int          d_w;    // W ready delay
    int          d_resp; // extra cycles before B/R
    logic [1:0]  resp;
    string       nm;
  } vec_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && resp_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check("resp_unexpected", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("resp_rdata", resp_rdata, mon_e.rdata);
        check("resp_code", 32'(resp_code), 32'(mon_e.code));
      end
    end
  end

  task automatic run_txn(input vec_t v);
    int   t0, c, lat_exp, guard;
    bit   a_done, w_done;
    exp_t e;
    @(negedge clk);
    check({v.nm, "_resp_pulse_end"}, 32'(resp_valid), 32'd0);
    check({v.nm, "_req_ready_idle"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_write = v.wr;
    req_addr  = v.addr;
    req_wdata = v.wr ? v.data : 32'h0;
    req_wstrb = v.strb;
    t0 = cyc;
    e.rdata = v.wr ? 32'h0 : v.data;
    e.code  = v.resp;
    sb.push_back(e);
    lat_exp = (v.wr ? ((v.d_a > v.d_w) ? v.d_a : v.d_w) : v.d_a) + v.d_resp + 3;

    @(negedge clk);
    req_valid = 1'b0;
    req_addr  = $urandom();
    req_wdata = $urandom();
    a_done = 1'b0;
    w_done = !v.wr;
    c = 1;
    while (!(a_done && w_done)) begin
      if (c > 100) begin
        check({v.nm, "_addr_phase_bound"}, 32'd0, 32'd1);
        break;
      end
      check({v.nm, "_req_ready_busy"}, 32'(req_ready), 32'd0);
      if (v.wr) begin
        if (!a_done) begin
          check({v.nm, "_awvalid"}, 32'(bus.awvalid), 32'd1);
          check({v.nm, "_awaddr"}, bus.awaddr, v.addr);
        end else begin
          check({v.nm, "_awvalid_drop"}, 32'(bus.awvalid), 32'd0);
        end
        if (!w_done) begin
          check({v.nm, "_wvalid"}, 32'(bus.wvalid), 32'd1);
          check({v.nm, "_wdata"}, bus.wdata, v.data);
          check({v.nm, "_wstrb"}, 32'(bus.wstrb), 32'(v.strb));
        end else begin
          check({v.nm, "_wvalid_drop"}, 32'(bus.wvalid), 32'd0);
        end
        bus.awready = !a_done && (c - 1 >= v.d_a);
        bus.wready  = !w_done && (c - 1 >= v.d_w);
      end else begin
        check({v.nm, "_arvalid"}, 32'(bus.arvalid), 32'd1);
        check({v.nm, "_araddr"}, bus.araddr, v.addr);
        bus.arready = (c - 1 >= v.d_a);
      end
      @(negedge clk);
      c++;
      if (v.wr) begin
        if (bus.awready) a_done = 1'b1;
        if (bus.wready)  w_done = 1'b1;
      end else if (bus.arready) begin
        a_done = 1'b1;
      end
    end
    bus.awready = 1'b0;
    bus.wready  = 1'b0;
    bus.arready = 1'b0;

    check({v.nm, "_valids_low"}, 32'({bus.awvalid, bus.wvalid, bus.arvalid}), 32'd0);
    for (int i = 0; i <= v.d_resp; i++) begin
      if (i > 0) @(negedge clk);
      check({v.nm, "_resp_ready"}, 32'({bus.bready, bus.rready}), v.wr ? 32'd2 : 32'd1);
    end
    if (v.wr) begin
      bus.bvalid = 1'b1;
      bus.bresp  = v.resp;
    end else begin
      bus.rvalid = 1'b1;
      bus.rresp  = v.resp;
      bus.rdata  = v.data;
    end
    @(negedge clk);
    bus.bvalid = 1'b0;
    bus.rvalid = 1'b0;
    bus.rdata  = $urandom();
    bus.bresp  = 2'b00;
    bus.rresp  = 2'b00;

    guard = 0;
    while (resp_valid !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check({v.nm, "_latency"}, 32'(cyc - t0), 32'(lat_exp));
    check({v.nm, "_req_ready_resp"}, 32'(req_ready), 32'd0);
    check({v.nm, "_ready_drop"}, 32'({bus.bready, bus.rready}), 32'd0);
  endtask

  vec_t vecs[8];

  initial begin
    req_valid = 1'b0; req_write = 1'b0; req_addr = 32'h0; req_wdata = 32'h0; req_wstrb = 4'h0;
    bus.awready = 1'b0; bus.wready = 1'b0; bus.arready = 1'b0;
    bus.bvalid = 1'b0; bus.bresp = 2'b00;
    bus.rvalid = 1'b0; bus.rresp = 2'b00; bus.rdata = 32'h0;

    //            wr  addr          data          strb  d_a d_w d_r resp   name
    vecs[0] = '{1'b1, 32'h0000_0008, 32'hA5A5_0001, 4'hF, 0, 0, 0, 2'b00, "wr_min"};
    vecs[1] = '{1'b1, 32'h0000_0008, 32'h0BAD_F00D, 4'hF, 3, 0, 0, 2'b00, "wr_w_first"};
    vecs[2] = '{1'b1, 32'h0000_0010, 32'h1111_2222, 4'h3, 0, 2, 1, 2'b01, "wr_aw_first_exok"};
    vecs[3] = '{1'b0, 32'h0000_0004, 32'h1234_5678, 4'h0, 2, 0, 0, 2'b00, "rd_ar_late"};
    vecs[4] = '{1'b1, 32'h0000_0020, 32'hCAFE_0001, 4'h5, 1, 1, 0, 2'b10, "wr_slverr"};
    vecs[5] = '{1'b0, 32'h0000_0024, 32'hDEAD_BEEF, 4'h0, 0, 0, 0, 2'b11, "rd_decerr"};
    vecs[6] = '{1'b0, 32'hFFFF_FFFC, 32'h8000_0001, 4'h0, 1, 0, 3, 2'b00, "rd_r_late"};
    vecs[7] = '{1'b1, 32'h0000_0000, 32'hFFFF_FFFF, 4'h8, 2, 2, 2, 2'b00, "wr_both_late"};

    @(negedge clk);
    @(negedge clk);
    check("rst_valids", 32'({bus.awvalid, bus.wvalid, bus.arvalid, bus.bready, bus.rready}), 32'd0);
    check("rst_resp", 32'({resp_valid, resp_code}), 32'd0);
    check("rst_rdata", resp_rdata, 32'd0);
    check("rst_addr", bus.awaddr, 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    rst_n = 1'b1;
    @(negedge clk);
`ifdef AXIL_CFG_MASTER_TIMEOUT_EN
    check("idle_readies", 32'({bus.bready, bus.rready}), 32'd3);
`else
    check("idle_readies", 32'({bus.bready, bus.rready}), 32'd0);
`endif

    for (int i = 0; i < 8; i++) run_txn(vecs[i]);

    // Reset while waiting for B
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h40; req_wdata = 32'h5555_AAAA; req_wstrb = 4'hF;
    bus.awready = 1'b1; bus.wready = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    bus.awready = 1'b0; bus.wready = 1'b0;
    check("rstw_in_wresp", 32'(bus.bready), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rstw_valids", 32'({bus.awvalid, bus.wvalid, bus.arvalid, bus.bready, bus.rready}), 32'd0);
    check("rstw_resp", 32'({resp_valid, resp_code}), 32'd0);
    check("rstw_req_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    bus.bvalid = 1'b1;
    @(negedge clk);
    bus.bvalid = 1'b0;
    repeat (4) @(negedge clk);
    check("rstw_req_ready_after", 32'(req_ready), 32'd1);

`ifdef AXIL_CFG_MASTER_TIMEOUT_EN
    begin
      int   t_ent, guard;
      exp_t e;
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h44;
      e.rdata = 32'h0; e.code = 2'b11;
      sb.push_back(e);
      bus.arready = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      bus.arready = 1'b0;
      check("to_rready", 32'(bus.rready), 32'd1);
      t_ent = cyc;
      guard = 0;
      while (resp_valid !== 1'b1 && guard < 100) begin
        @(negedge clk);
        guard++;
      end
      check("to_latency", 32'(cyc - t_ent), 32'd16);
      @(negedge clk);
      check("to_idle_readies", 32'({bus.bready, bus.rready}), 32'd3);
      bus.rvalid = 1'b1; bus.rdata = 32'h7777_7777;
      @(negedge clk);
      bus.rvalid = 1'b0;
      repeat (4) @(negedge clk);
      check("to_late_req_ready", 32'(req_ready), 32'd1);
    end
`endif

    @(negedge clk);
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

endmodule

`default_nettype wire
